uart_rx: RTL and testbench

UART receiver peripheral for the 3-stage RISC-V core, the receive-side counterpart of the existing uart_tx on the peripherals bus.
- Oversamples the serial line and deframes 8N1 characters, LSB first.
- Buffers received bytes in a small FIFO.
- Exposes a data register and a status register to load instructions through the peripherals bus chip-select.
- rx_valid_o is available to drive the core's external interrupt input.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sync_fifo.sv | 55 +++++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state codes, register map, STATUS layout and baud divisor.
`timescale 1ns/1ps
package uart_pkg;

   localparam logic [2:0] RxIdle  = 3'd0;
   localparam logic [2:0] RxStart = 3'd1;
   localparam logic [2:0] RxData  = 3'd2;
   localparam logic [2:0] RxStop  = 3'd3;
   localparam logic [2:0] RxBreak = 3'd4;

   localparam logic RegRxData = 1'b0;
   localparam logic RegStatus = 1'b1;

   localparam int unsigned StatNotEmpty = 0;
   localparam int unsigned StatFull     = 1;
   localparam int unsigned StatFrameErr = 2;
   localparam int unsigned StatOverrun  = 3;
   localparam int unsigned StatCountLsb = 4;

   // Clock cycles per oversample tick, rounded down and never below one.
   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned os);
      int unsigned d;
      d = clk_freq / (baud * os);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Small synchronous FIFO; a pop and a push in the same cycle are both honoured even when full.
`timescale 1ns/1ps
module sync_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampling deframer, receive FIFO and RXDATA/STATUS bus registers.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DW         = 8,
   parameter int unsigned CLOCK_FREQ = 100_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rx_i,
   input  logic        cs,
   input  logic        re,
   input  logic        addr_i,
   output logic [31:0] rdata_o,
   output logic        rx_valid_o,
   output logic        frame_err_o,
   output logic        overrun_o
);

   localparam int unsigned DIV  = baud_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SW   = $clog2(OVERSAMPLE);
   localparam int unsigned BW   = $clog2(DW + 1);
   localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]      sync_q;
   logic            rx_s;
   logic [DivW-1:0] div_q, div_d;
   logic            tick;
   logic [2:0]      state_q, state_d;
   logic [SW-1:0]   scnt_q, scnt_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic [DW-1:0]   shreg_q, shreg_d;
   logic            frame_err_q, frame_err_d, overrun_q, overrun_d;
   logic            push_evt, fe_evt, ov_evt, rd_data, rd_stat;
   logic [DW-1:0]   fifo_rdata;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;

   assign rx_s = sync_q[1];
   assign tick = (div_q == DivW'(DIV - 1));
   assign div_d = tick ? '0 : div_q + DivW'(1);

   always_comb begin
      state_d  = state_q;
      scnt_d   = scnt_q;
      bcnt_d   = bcnt_q;
      shreg_d  = shreg_q;
      push_evt = 1'b0;
      fe_evt   = 1'b0;
      if (tick) begin
         case (state_q)
            RxIdle: if (!rx_s) begin
               scnt_d  = '0;
               state_d = RxStart;
            end
            RxStart: if (scnt_q == SW'(OVERSAMPLE / 2 - 1)) begin
               if (rx_s) begin
                  state_d = RxIdle;
               end else begin
                  scnt_d  = '0;
                  bcnt_d  = '0;
                  state_d = RxData;
               end
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
            // Right shift so the first bit received ends up in bit 0.
            RxData: if (scnt_q == SW'(OVERSAMPLE - 1)) begin
               scnt_d  = '0;
               shreg_d = {rx_s, shreg_q[DW-1:1]};
               bcnt_d  = bcnt_q + BW'(1);
               if (bcnt_q == BW'(DW - 1)) state_d = RxStop;
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
            RxStop: if (scnt_q == SW'(OVERSAMPLE - 1)) begin
               if (rx_s) begin
                  push_evt = 1'b1;
                  state_d  = RxIdle;
               end else begin
                  fe_evt  = 1'b1;
                  state_d = RxBreak;
               end
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
            RxBreak: if (rx_s) state_d = RxIdle;
            default: state_d = RxIdle;
         endcase
      end
   end

   assign rd_data = cs & re & (addr_i == RegRxData);
   assign rd_stat = cs & re & (addr_i == RegStatus);
   // A full FIFO being popped this cycle still has room for the new byte.
   assign ov_evt  = push_evt & fifo_full & ~rd_data;

   assign frame_err_d = fe_evt | (frame_err_q & ~rd_stat);
   assign overrun_d   = ov_evt | (overrun_q & ~rd_stat);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q      <= 2'b11;
         div_q       <= '0;
         state_q     <= RxIdle;
         scnt_q      <= '0;
         bcnt_q      <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], rx_i};
         div_q       <= div_d;
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         bcnt_q      <= bcnt_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   sync_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_evt),
      .pop_i   (rd_data),
      .wdata_i (shreg_q),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      rdata_o = '0;
      if (rd_data && !fifo_empty) begin
         rdata_o = 32'(fifo_rdata);
      end else if (rd_stat) begin
         rdata_o[StatNotEmpty]      = ~fifo_empty;
         rdata_o[StatFull]          = fifo_full;
         rdata_o[StatFrameErr]      = frame_err_q;
         rdata_o[StatOverrun]       = overrun_q;
         rdata_o[StatCountLsb +: 4] = 4'(fifo_count);
      end
   end

   assign rx_valid_o  = ~fifo_empty;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at one tick per clock (16 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        cs = 1'b0;
   logic        re = 1'b0;
   logic        addr = 1'b0;
   logic [31:0] rdata;
   logic        rx_valid, fe, ov;

   int   tests = 0;
   int   fails = 0;
   logic v_before = 1'b0;
   logic v_after = 1'b0;
   int   fe_rises = 0;
   logic fe_prev = 1'b0;

   uart_rx #(
      .DW         (8),
      .CLOCK_FREQ (1_600_000),
      .BAUD_RATE  (100_000),
      .OVERSAMPLE (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rx_i        (rx),
      .cs          (cs),
      .re          (re),
      .addr_i      (addr),
      .rdata_o     (rdata),
      .rx_valid_o  (rx_valid),
      .frame_err_o (fe),
      .overrun_o   (ov)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fe && !fe_prev) fe_rises = fe_rises + 1;
      fe_prev = fe;
   end

   task automatic tick_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic a, output logic [31:0] d);
      cs = 1'b1; re = 1'b1; addr = a;
      #1 d = rdata;
      @(posedge clk);
      #1 cs = 1'b0; re = 1'b0; addr = 1'b0;
   endtask

   // Frame starts now (just after an edge); rx_valid is sampled around the stop-bit push edge.
   task automatic send_frame(input logic [7:0] data, input logic stop, input int stop_len);
      rx = 1'b0;
      tick_wait(16);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         tick_wait(16);
      end
      rx = stop;
      tick_wait(10);
      v_before = rx_valid;
      tick_wait(1);
      v_after = rx_valid;
      tick_wait(stop_len - 11);
      rx = 1'b1;
      tick_wait(4);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx = 1'b1; cs = 1'b1; re = 1'b1; addr = 1'b1;
      tick_wait(3);
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rx_valid); end
      tests++; if (fe !== 1'b0) begin fails++; $display("FAIL reset_fe got %b want 0", fe); end
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_ov got %b want 0", ov); end
      tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
      cs = 1'b0; re = 1'b0; addr = 1'b0;
      rst_n = 1'b1;
      tick_wait(5);
   endtask

   task automatic test_single();
      logic [31:0] d;
      send_frame(8'hA5, 1'b1, 16);
      tests++; if (v_before !== 1'b0 || v_after !== 1'b1) begin
         fails++; $display("FAIL a5_latency got %b%b want 01", v_before, v_after);
      end
      bus_read(1'b1, d);
      tests++; if (d !== 32'h11) begin fails++; $display("FAIL a5_status got %h want 11", d); end
      bus_read(1'b0, d);
      tests++; if (d !== 32'hA5) begin fails++; $display("FAIL a5_data got %h want a5", d); end
      bus_read(1'b1, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL a5_status_after got %h want 0", d); end
   endtask

   task automatic test_false_start();
      rx = 1'b0;
      tick_wait(4);
      rx = 1'b1;
      tick_wait(30);
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
      tests++; if (fe !== 1'b0) begin fails++; $display("FAIL glitch_fe got %b want 0", fe); end
      tests++; if (dut.state_q !== RxIdle) begin
         fails++; $display("FAIL glitch_state got %0d want %0d", dut.state_q, RxIdle);
      end
   endtask

   task automatic test_frame_error();
      logic [31:0] d;
      int          rises0;
      rises0 = fe_rises;
      send_frame(8'h3C, 1'b0, 40);
      tick_wait(20);
      tests++; if (fe_rises - rises0 !== 1) begin
         fails++; $display("FAIL fe_once got %0d rises want 1", fe_rises - rises0);
      end
      tests++; if (fe !== 1'b1) begin fails++; $display("FAIL fe_set got %b want 1", fe); end
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL fe_empty got %b want 0", rx_valid); end
      bus_read(1'b1, d);
      tests++; if (d !== 32'h4) begin fails++; $display("FAIL fe_status got %h want 4", d); end
      tests++; if (fe !== 1'b0) begin fails++; $display("FAIL fe_clear got %b want 0", fe); end
      send_frame(8'h55, 1'b1, 16);
      bus_read(1'b0, d);
      tests++; if (d !== 32'h55) begin fails++; $display("FAIL fe_next_data got %h want 55", d); end
   endtask

   task automatic test_overrun();
      logic [31:0] d;
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 16);
      tests++; if (ov !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", ov); end
      bus_read(1'b1, d);
      tests++; if (d !== 32'h4B) begin fails++; $display("FAIL ovr_status got %h want 4b", d); end
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", ov); end
      for (int b = 1; b <= 4; b++) begin
         bus_read(1'b0, d);
         tests++; if (d !== 32'(b)) begin fails++; $display("FAIL ovr_data%0d got %h want %h", b, d, b); end
      end
      bus_read(1'b0, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL ovr_empty_read got %h want 0", d); end
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_drained got %b want 0", rx_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [31:0] hd;
      for (int b = 0; b < 4; b++) send_frame(8'h10 + 8'(b), 1'b1, 16);
      bus_read(1'b1, d);
      tests++; if (d !== 32'h43) begin fails++; $display("FAIL b2b_full got %h want 43", d); end
      fork
         send_frame(8'h14, 1'b1, 16);
         begin
            tick_wait(154);
            cs = 1'b1; re = 1'b1; addr = 1'b0;
            #1 hd = rdata;
            @(posedge clk);
            #1 cs = 1'b0; re = 1'b0;
         end
      join
      tests++; if (hd !== 32'h10) begin fails++; $display("FAIL b2b_head got %h want 10", hd); end
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL b2b_ov got %b want 0", ov); end
      bus_read(1'b1, d);
      tests++; if (d !== 32'h43) begin fails++; $display("FAIL b2b_status got %h want 43", d); end
      for (int b = 1; b <= 4; b++) begin
         bus_read(1'b0, d);
         tests++; if (d !== 32'h10 + 32'(b)) begin
            fails++; $display("FAIL b2b_data%0d got %h want %h", b, d, 32'h10 + 32'(b));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      send_frame(8'h99, 1'b1, 16);
      tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL rm_pre got %b want 1", rx_valid); end
      rx = 1'b0; tick_wait(16);
      rx = 1'b0; tick_wait(16);
      rx = 1'b1; tick_wait(18);
      rst_n = 1'b0; cs = 1'b1; re = 1'b1; addr = 1'b1;
      #1;
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rm_valid got %b want 0", rx_valid); end
      tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rm_rdata got %h want 0", rdata); end
      tests++; if (fe !== 1'b0 || ov !== 1'b0) begin fails++; $display("FAIL rm_flags got %b%b want 00", fe, ov); end
      rx = 1'b1;
      tick_wait(3);
      cs = 1'b0; re = 1'b0; addr = 1'b0;
      rst_n = 1'b1;
      tick_wait(10);
      send_frame(8'h7E, 1'b1, 16);
      bus_read(1'b0, d);
      tests++; if (d !== 32'h7E) begin fails++; $display("FAIL rm_data got %h want 7e", d); end
      bus_read(1'b1, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL rm_status got %h want 0", d); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_false_start();
      test_frame_error();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
